div_sequencer: RTL and testbench

Multi-cycle controller and iterative datapath for the RV32M divide group (DIV, DIVU, REM, REMU) in the EX stage. It latches operands when a divide reaches EX and runs a 32-step radix-2 restoring division. While it runs, it asserts a stall so the control path holds PC, IF/ID and ID/EX. It then presents a single-cycle-valid result to the EX result mux.

---
 rtl/div_sequencer.sv | 125 ++++++++++++
 tb/tb_div_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Iterative RV32M divide unit (DIV, DIVU, REM, REMU) for the EX stage.
// Latches operands on start, then runs one radix-2 restoring step per cycle.
// After that it fixes up the signs and presents a one-cycle-valid result.
// Divide-by-zero and signed overflow bypass the iteration and complete in one cycle.
//
// state | meaning
// IDLE  | waiting for a divide in EX; accepts and latches operands
// CALC  | one restoring-division step per cycle, XLEN steps
// FIX   | apply result signs and select quotient or remainder
// DONE  | result valid for one cycle; the instruction leaves EX
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   counter;
  logic [XLEN-1:0] divisor, rem, quo, result;
  logic            sel_rem, quot_neg, rem_neg;

  logic            accept, is_signed, div_zero, overflow, special;
  logic [XLEN-1:0] special_res, dividend_abs, divisor_abs;
  logic [XLEN:0]   rem_sh, trial;

  // Acceptance and special-case detection on the live operands.
  // accept also drops during reset, so stall_o is low while rst_n is asserted.
  assign accept       = rst_n & (state == IDLE) & start_i & ~flush_i;
  assign is_signed    = ~op_i[0];
  assign div_zero     = (rs2_i == '0);
  assign overflow     = is_signed & (rs1_i == MIN_NEG) & (rs2_i == '1);
  assign special      = div_zero | overflow;
  assign special_res  = div_zero ? (op_i[1] ? rs1_i : '1)
                                 : (op_i[1] ? '0 : MIN_NEG);
  assign dividend_abs = (is_signed & rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
  assign divisor_abs  = (is_signed & rs2_i[XLEN-1]) ? -rs2_i : rs2_i;

  // The shifted partial remainder is below 2*divisor, so bit XLEN of the
  // trial difference is exactly the borrow, i.e. "did not fit".
  assign rem_sh = {rem, quo[XLEN-1]};
  assign trial  = rem_sh - {1'b0, divisor};

  assign stall_o  = accept | (state == CALC) | (state == FIX);
  assign busy_o   = (state == CALC) | (state == FIX);
  assign valid_o  = (state == DONE);
  assign result_o = result;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a flush returns to IDLE from any state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = special ? DONE : CALC;
      CALC: begin
        if (flush_i)              state_nxt = IDLE;
        else if (counter == LAST) state_nxt = FIX;
      end
      FIX:  state_nxt = flush_i ? IDLE : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, division steps, and result fix-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter  <= '0;
      divisor  <= '0;
      rem      <= '0;
      quo      <= '0;
      result   <= '0;
      sel_rem  <= 1'b0;
      quot_neg <= 1'b0;
      rem_neg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sel_rem  <= op_i[1];
            divisor  <= divisor_abs;
            quo      <= dividend_abs;
            rem      <= '0;
            counter  <= '0;
            quot_neg <= is_signed & (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
            rem_neg  <= is_signed & rs1_i[XLEN-1];
            if (special) result <= special_res;
          end
        end
        CALC: begin
          rem     <= trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
          quo     <= {quo[XLEN-2:0], ~trial[XLEN]};
          counter <= counter + 1'b1;
        end
        FIX: begin
          if (!flush_i)
            result <= sel_rem ? (rem_neg  ? -rem : rem)
                              : (quot_neg ? -quo : quo);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: the driver pushes the expected result and latency.
// The monitor pops and compares on every valid_o.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_o, busy_o, valid_o;
  logic [31:0] result_o;

  div_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i),
    .stall_o(stall_o), .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   n_valid = 0;
  int   n_pushed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: RISC-V M semantics written with plain SystemVerilog arithmetic.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   model = (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      2'b01:   model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   model = (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Monitor: every valid_o must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && valid_o) begin
      n_valid++;
      if (q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", result_o, e.res);
        chk("latency", 32'(cyc - e.cyc), 32'(e.lat));
      end
    end
  end

  // Issue one op at a negedge; hold start until valid, and return at the next negedge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit chain);
    int  stalls;
    bit  got;
    int  exp_stall;
    exp_t e;
    exp_stall = is_special(op, a, b) ? 1 : 34;
    start_i = 1'b1;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    e.res = model(op, a, b);
    e.cyc = cyc;
    e.lat = exp_stall;
    q.push_back(e);
    n_pushed++;
    stalls = 0;
    got    = 0;
    #1;
    for (int k = 0; k < 80 && !got; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      if (valid_o) got = 1;
      else if (stall_o) stalls++;
    end
    chk("valid_seen", 32'(got), 32'd1);
    chk("stall_cycles", 32'(stalls), 32'(exp_stall));
    @(negedge clk);
    if (!chain) start_i = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_op(2'b01, 32'd100, 32'd7, 0);
    run_op(2'b11, 32'd100, 32'd7, 0);
    run_op(2'b00, -32'sd7, 32'd2, 0);
    run_op(2'b10, -32'sd7, 32'd2, 0);
    run_op(2'b00, 32'd7, -32'sd2, 0);
    run_op(2'b01, 32'd5, 32'd0, 0);
    run_op(2'b10, 32'h8000_0000, 32'd0, 0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    // Flush at CALC step 10.
    start_i = 1'b1; op_i = 2'b01; rs1_i = 32'd1000; rs2_i = 32'd7;
    repeat (11) @(negedge clk);
    chk("busy_before_flush", 32'(busy_o), 32'd1);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    start_i = 1'b0;
    #1;
    chk("flush_stall", 32'(stall_o), 32'd0);
    chk("flush_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    run_op(2'b01, 32'd9, 32'd3, 0);

    // Asynchronous reset mid-CALC.
    start_i = 1'b1; op_i = 2'b01; rs1_i = 32'd12345; rs2_i = 32'd3;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_stall", 32'(stall_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_result", result_o, 32'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 0);

    // Back-to-back with start held high.
    run_op(2'b01, 32'd50, 32'd5, 1);
    run_op(2'b01, 32'd81, 32'd9, 0);

    // Randomized ops with biased divisors to hit the special cases.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
        2:       b = 32'($urandom_range(1, 20));
        3:       b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_op(op, a, b, ($urandom_range(0, 1) == 1));
    end
    start_i = 1'b0;

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("valid_count", 32'(n_valid), 32'(n_pushed));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
